// File: rtl/uart_loader_pkg.sv
// Shared types and protocol constants for the UART memory loader.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_EXEC,
      S_RDWAIT,
      S_RESP,
      S_TXWAIT
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_WRITE) || (b == CMD_READ);
   endfunction

endpackage

// File: rtl/uart_loader_byte_shift_reg32.sv
// 32-bit byte shift register: bytes enter at the MSB end and leave from the LSB end.
module byte_shift_reg32 (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_shift,
   input  logic [7:0]  i_byte,
   input  logic        i_load,
   input  logic [31:0] i_load_val,
   output logic [31:0] o_q,
   output logic [7:0]  o_lsb
);

   logic [31:0] r_q;

   // Parallel load wins over shift when both are requested.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_shift) begin
         r_q <= {i_byte, r_q[31:8]};
      end
   end

   assign o_q   = r_q;
   assign o_lsb = r_q[7:0];

endmodule

// File: rtl/uart_loader.sv
// UART command responder performing 32-bit word reads/writes on a memory port.
// Optional inter-byte timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        err_overrun
);

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic [2:0]  r_rsp_left;
   logic        r_is_write;
   logic [7:0]  r_tx_data;
   logic        r_tx_start;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_mem_we;
   logic        r_mem_re;
   logic        r_busy;
   logic        r_err_overrun;
`ifdef UART_LOADER_TIMEOUT_EN
   logic [31:0] r_idle_cnt;
`else
   logic        w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

   logic [31:0] w_addr_q;
   logic [31:0] w_data_q;
   logic [31:0] w_addr_full;
   logic [7:0]  w_unused_addr_lsb;
   logic [7:0]  w_unused_data_lsb;
   logic        w_a_shift;
   logic        w_d_shift;
   logic [7:0]  w_d_byte;
   logic        w_d_load;
   logic [31:0] w_d_val;
   logic        w_tx_fire;
   logic        w_drop;

   byte_shift_reg32 u_addr_sr (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_shift    (w_a_shift),
      .i_byte     (rx_data),
      .i_load     (1'b0),
      .i_load_val ('0),
      .o_q        (w_addr_q),
      .o_lsb      (w_unused_addr_lsb)
   );

   byte_shift_reg32 u_data_sr (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_shift    (w_d_shift),
      .i_byte     (w_d_byte),
      .i_load     (w_d_load),
      .i_load_val (w_d_val),
      .o_q        (w_data_q),
      .o_lsb      (w_unused_data_lsb)
   );

   // The data register doubles as the response buffer; single-byte replies are loaded into its LSB.
   always_comb begin
      w_addr_full = {rx_data, w_addr_q[31:8]};
      w_tx_fire   = (r_state == S_RESP) && !tx_busy;
      w_a_shift   = (r_state == S_ADDR) && rx_ready;
      w_d_shift   = ((r_state == S_DATA) && rx_ready) || w_tx_fire;
      w_d_byte    = (r_state == S_DATA) ? rx_data : '0;
      w_drop      = rx_ready && ((r_state == S_EXEC) || (r_state == S_RDWAIT) ||
                                 (r_state == S_RESP) || (r_state == S_TXWAIT));
      w_d_load    = 1'b0;
      w_d_val     = '0;
      case (r_state)
         S_IDLE: begin
            if (rx_ready && !is_cmd(rx_data)) begin
               w_d_load = 1'b1;
               w_d_val  = {24'h0, RSP_ERR};
            end
         end
         S_ADDR: begin
            if (rx_ready && (r_cnt == 2'd3) && (w_addr_full[1:0] != 2'b00)) begin
               w_d_load = 1'b1;
               w_d_val  = {24'h0, RSP_ERR};
            end
         end
         S_EXEC: begin
            if (r_is_write) begin
               w_d_load = 1'b1;
               w_d_val  = {24'h0, RSP_OK};
            end
         end
         S_RDWAIT: begin
            w_d_load = 1'b1;
            w_d_val  = mem_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_rsp_left    <= '0;
         r_is_write    <= 1'b0;
         r_tx_data     <= '0;
         r_tx_start    <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_we      <= 1'b0;
         r_mem_re      <= 1'b0;
         r_busy        <= 1'b0;
         r_err_overrun <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
         r_idle_cnt    <= '0;
`endif
      end else begin
         r_tx_start <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_re   <= 1'b0;
         if (w_drop) begin
            r_err_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
`ifdef UART_LOADER_TIMEOUT_EN
               r_idle_cnt <= '0;
`endif
               if (rx_ready) begin
                  r_busy <= 1'b1;
                  r_cnt  <= '0;
                  if (is_cmd(rx_data)) begin
                     r_is_write <= (rx_data == CMD_WRITE);
                     r_state    <= S_ADDR;
                  end else begin
                     r_rsp_left <= 3'd1;
                     r_state    <= S_RESP;
                  end
               end
            end
            S_ADDR: begin
               if (rx_ready) begin
`ifdef UART_LOADER_TIMEOUT_EN
                  r_idle_cnt <= '0;
`endif
                  if (r_cnt == 2'd3) begin
                     r_cnt <= '0;
                     if (w_addr_full[1:0] != 2'b00) begin
                        r_rsp_left <= 3'd1;
                        r_state    <= S_RESP;
                     end else if (r_is_write) begin
                        r_state <= S_DATA;
                     end else begin
                        r_mem_addr <= w_addr_full;
                        r_mem_re   <= 1'b1;
                        r_state    <= S_EXEC;
                     end
                  end else begin
                     r_cnt <= r_cnt + 2'd1;
                  end
               end
`ifdef UART_LOADER_TIMEOUT_EN
               else if (r_idle_cnt == TIMEOUT_CYCLES) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 32'd1;
               end
`endif
            end
            S_DATA: begin
               if (rx_ready) begin
`ifdef UART_LOADER_TIMEOUT_EN
                  r_idle_cnt <= '0;
`endif
                  if (r_cnt == 2'd3) begin
                     r_cnt       <= '0;
                     r_mem_addr  <= w_addr_q;
                     r_mem_wdata <= {rx_data, w_data_q[31:8]};
                     r_mem_we    <= 1'b1;
                     r_state     <= S_EXEC;
                  end else begin
                     r_cnt <= r_cnt + 2'd1;
                  end
               end
`ifdef UART_LOADER_TIMEOUT_EN
               else if (r_idle_cnt == TIMEOUT_CYCLES) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 32'd1;
               end
`endif
            end
            S_EXEC: begin
               r_cnt <= '0;
               if (r_is_write) begin
                  r_rsp_left <= 3'd1;
                  r_state    <= S_RESP;
               end else begin
                  r_state <= S_RDWAIT;
               end
            end
            S_RDWAIT: begin
               r_cnt      <= '0;
               r_rsp_left <= 3'd4;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (!tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= w_data_q[7:0];
                  r_rsp_left <= r_rsp_left - 3'd1;
                  r_cnt      <= '0;
                  r_state    <= S_TXWAIT;
               end
            end
            S_TXWAIT: begin
               // First cycle only covers the transmitter's one-cycle busy latency.
               if (r_cnt == 2'd0) begin
                  r_cnt <= 2'd1;
               end else if (!tx_busy) begin
                  r_cnt <= '0;
                  if (r_rsp_left != 3'd0) begin
                     r_state <= S_RESP;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_data     = r_tx_data;
   assign tx_start    = r_tx_start;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_we      = r_mem_we;
   assign mem_re      = r_mem_re;
   assign busy        = r_busy;
   assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_loader.sv
// Randomized self-checking bench for uart_loader with a command-level reference model.
module tb_uart_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata = '0;
   logic        busy;
   logic        err_overrun;

   always #5 clk = ~clk;

   uart_loader #(.TIMEOUT_CYCLES(100)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .err_overrun (err_overrun)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference memory (driven by commands sent) and device memory (driven by DUT strobes).
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dev_mem [logic [31:0]];

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5EED_1234;
   endfunction

   int unsigned cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   logic [7:0]  tx_q[$];
   logic [31:0] we_addr_q[$];
   logic [31:0] we_data_q[$];
   logic [31:0] re_addr_q[$];
   int unsigned we_cyc, re_cyc, rx_cyc;
   int          proto_viol = 0;
   logic        prev_txs = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_ready) rx_cyc = cyc;
         if (mem_we) begin
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
            we_cyc = cyc;
            dev_mem[mem_addr] = mem_wdata;
         end
         if (mem_re) begin
            re_addr_q.push_back(mem_addr);
            re_cyc = cyc;
         end
         if (tx_start) begin
            tx_q.push_back(tx_data);
            if (prev_txs || tx_busy) proto_viol++;
         end
         prev_txs = tx_start;
      end else begin
         prev_txs = 1'b0;
      end
   end

   // Memory device: read data valid only in the cycle after mem_re.
   initial forever begin
      logic [31:0] a;
      @(negedge clk);
      if (rst_n && mem_re) begin
         a = mem_addr;
         @(posedge clk);
         #1 mem_rdata = dev_mem.exists(a) ? dev_mem[a] : mem_init(a);
         @(posedge clk);
         #1 mem_rdata = $urandom;
      end
   end

   // Transmitter: busy from the cycle after tx_start for a random length.
   initial forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
         @(posedge clk);
         #1 tx_busy = 1'b1;
         repeat ($urandom_range(1, 6)) @(posedge clk);
         #1 tx_busy = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic clear_mon();
      tx_q.delete();
      we_addr_q.delete();
      we_data_q.delete();
      re_addr_q.delete();
      proto_viol = 0;
   endtask

   logic [7:0]  cmd_q[$];
   logic [7:0]  exp_tx[$];
   bit          exp_we, exp_re;
   logic [31:0] exp_addr, exp_wdata;

   task automatic model_cmd();
      logic [31:0] a, d, v;
      exp_tx.delete();
      exp_we = 0;
      exp_re = 0;
      if (cmd_q[0] == 8'h57 || cmd_q[0] == 8'h52) begin
         a = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
         if (a % 4 != 0) begin
            exp_tx.push_back(8'h3F);
         end else if (cmd_q[0] == 8'h57) begin
            d = {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]};
            ref_mem[a] = d;
            exp_we = 1;
            exp_addr = a;
            exp_wdata = d;
            exp_tx.push_back(8'h4B);
         end else begin
            v = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
            exp_re = 1;
            exp_addr = a;
            for (int k = 0; k < 4; k++) exp_tx.push_back(8'((v >> (8 * k)) & 32'hFF));
         end
      end else begin
         exp_tx.push_back(8'h3F);
      end
   endtask

   task automatic run_cmd(input bit inject, input int pause);
      int unsigned last_rx;
      int k;
      clear_mon();
      model_cmd();
      foreach (cmd_q[i]) begin
         send_byte(cmd_q[i]);
         if (i == 0) begin
            @(negedge clk);
            check_eq("busy_rise", 32'(busy), 32'd1);
         end
         if (i == 1 && pause > 0) begin
            repeat (pause) @(posedge clk);
            @(negedge clk);
            check_eq("busy_hold", 32'(busy), 32'd1);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      last_rx = rx_cyc;
      if (inject) begin
         k = 0;
         while (tx_q.size() == 0 && k < 2000) begin
            @(posedge clk);
            k++;
         end
         send_byte(8'hA5);
      end
      k = 0;
      while (busy && k < 3000) begin
         @(posedge clk);
         k++;
      end
      check_eq("busy_end", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_eq("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
         check_eq($sformatf("tx_byte%0d", i), 32'(tx_q[i]), 32'(exp_tx[i]));
      check_eq("we_count", 32'(we_addr_q.size()), 32'(exp_we));
      check_eq("re_count", 32'(re_addr_q.size()), 32'(exp_re));
      if (exp_we && we_addr_q.size() == 1) begin
         check_eq("we_addr", we_addr_q[0], exp_addr);
         check_eq("we_data", we_data_q[0], exp_wdata);
         check_eq("we_latency", we_cyc, last_rx + 1);
      end
      if (exp_re && re_addr_q.size() == 1) begin
         check_eq("re_addr", re_addr_q[0], exp_addr);
         check_eq("re_latency", re_cyc, last_rx + 1);
      end
      check_eq("tx_proto", 32'(proto_viol), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
      check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check_eq({tag, "_mem_re"}, 32'(mem_re), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_overrun"}, 32'(err_overrun), 32'd0);
   endtask

   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [7:0]  c;
      int          op;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst0");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      ref_mem[32'h100] = 32'hCAFEF00D;
      dev_mem[32'h100] = 32'hCAFEF00D;
      cmd_q = {8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
      run_cmd(0, 0);

      cmd_q = {8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_cmd(0, 0);

      cmd_q = {8'h41};
      run_cmd(0, 0);

      cmd_q = {8'h57, 8'h02, 8'h00, 8'h00, 8'h00};
      run_cmd(0, 0);

      check_eq("overrun_clear", 32'(err_overrun), 32'd0);
      cmd_q = {8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
      run_cmd(1, 0);
      check_eq("overrun_set", 32'(err_overrun), 32'd1);

      // Reset mid-write after six bytes.
      clear_mon();
      cmd_q = {8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h11};
      foreach (cmd_q[i]) send_byte(cmd_q[i]);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_eq("rst_no_we", 32'(we_addr_q.size()), 32'd0);
      check_eq("rst_no_tx", 32'(tx_q.size()), 32'd0);
      cmd_q = {8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      run_cmd(0, 0);

`ifdef UART_LOADER_TIMEOUT_EN
      clear_mon();
      send_byte(8'h52);
      send_byte(8'h00);
      repeat (101) @(posedge clk);
      @(negedge clk);
      check_eq("timeout_busy", 32'(busy), 32'd0);
      check_eq("timeout_no_tx", 32'(tx_q.size()), 32'd0);
      check_eq("timeout_no_re", 32'(re_addr_q.size()), 32'd0);
      cmd_q = {8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
      run_cmd(0, 0);
`else
      cmd_q = {8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
      run_cmd(0, 150);
`endif

      for (int n = 0; n < 30; n++) begin
         op = $urandom_range(0, 9);
         a  = ($urandom_range(0, 1) * 32'h1000_0000) + 32'($urandom_range(0, 7)) * 4;
         d  = $urandom;
         if (op == 9) a = a | 32'($urandom_range(1, 3));
         if (op == 8) begin
            c = 8'($urandom);
            if (c == 8'h57 || c == 8'h52) c = 8'h00;
            cmd_q = {c};
         end else if (op < 4 || (op == 9 && a[4])) begin
            cmd_q = {8'h57, a[7:0], a[15:8], a[23:16], a[31:24]};
            if (a[1:0] == 2'b00) begin
               cmd_q.push_back(d[7:0]);
               cmd_q.push_back(d[15:8]);
               cmd_q.push_back(d[23:16]);
               cmd_q.push_back(d[31:24]);
            end
         end else begin
            cmd_q = {8'h52, a[7:0], a[15:8], a[23:16], a[31:24]};
         end
         run_cmd(0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
